oam_write_queue: RTL and testbench

OAM_WRITE_QUEUE -- requirements
Module: oam_write_queue

---
 rtl/oam_write_queue_pkg.sv | 25 ++
 rtl/oam_write_queue_fifo.sv | 62 ++++++
 rtl/oam_write_queue.sv | 141 ++++++++++++++
 tb/tb_oam_write_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/oam_write_queue_pkg.sv
// Shared constants for the OAM write queue: field codes, drain FSM states
// and the field-width helper.
package oam_write_queue_pkg;

   typedef enum logic [1:0] {
      FIELD_X    = 2'd0,
      FIELD_Y    = 2'd1,
      FIELD_TILE = 2'd2,
      FIELD_ATTR = 2'd3
   } oam_field_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_WAIT_VB = 2'd2
   } drain_state_e;

   localparam int unsigned BYTE_FIELD_W = 8;

   // Tile and attribute fields only carry an 8-bit value.
   function automatic logic is_byte_field(input logic [1:0] field);
      return (field == FIELD_TILE) || (field == FIELD_ATTR);
   endfunction

endpackage

// File: rtl/oam_write_queue_fifo.sv
// Circular FIFO holding pending OAM writes; pushes and pops arrive pre-qualified.
module oam_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 18
) (
   input  logic                    clk,
   input  logic                    rst_ni,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [WIDTH-1:0]        wdata_i,
   output logic [WIDTH-1:0]        head_c_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_c_o = mem_q[rptr_q];
   assign count_o  = count_q;

endmodule

// File: rtl/oam_write_queue.sv
// Buffers CPU OAM writes and replays them into OAM, in order, only during vblank.
module oam_write_queue
   import oam_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned SNUM_W = 6,
   parameter int unsigned DATA_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    oam_we,
   input  logic [SNUM_W-1:0]       oam_snum,
   input  logic [1:0]              oam_field,
   input  logic [DATA_W-1:0]       oam_data,
   input  logic                    vblank,
   output logic                    cpu_stall,
   output logic                    oam_wr_en,
   output logic [SNUM_W+1:0]       oam_wr_addr,
   output logic [DATA_W-1:0]       oam_wr_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    drain_done
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ADDR_W  = SNUM_W + 2;
   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
   localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'({BYTE_FIELD_W{1'b1}});

   drain_state_e      state_q, state_d;
   logic [CNT_W-1:0]  fifo_count;
   logic [ENTRY_W-1:0] wr_entry, head_entry;
   logic [DATA_W-1:0] data_masked;
   logic              full, push_ok, pop, last_pop;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;

   // Full is judged on the registered count, so a pop never makes room the same cycle.
   assign full        = (fifo_count == CNT_W'(DEPTH));
   assign push_ok     = oam_we && !full;
   assign data_masked = is_byte_field(oam_field) ? (oam_data & BYTE_MASK) : oam_data;
   assign wr_entry    = {oam_snum, oam_field, data_masked};

   oam_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst_ni   (rst),
      .push_i   (push_ok),
      .pop_i    (pop),
      .wdata_i  (wr_entry),
      .head_c_o (head_entry),
      .count_o  (fifo_count)
   );

   // Drain FSM: the first pop happens on the cycle vblank is seen with data queued.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      last_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vblank) begin
               if (fifo_count != '0) begin
                  pop      = 1'b1;
                  last_pop = (fifo_count == CNT_W'(1)) && !push_ok;
                  state_d  = last_pop ? ST_WAIT_VB : ST_DRAIN;
               end else begin
                  state_d = ST_WAIT_VB;
               end
            end
         end
         ST_DRAIN: begin
            if (!vblank) begin
               state_d = ST_IDLE;
            end else if (fifo_count == '0) begin
               state_d = ST_WAIT_VB;
            end else begin
               pop      = 1'b1;
               last_pop = (fifo_count == CNT_W'(1)) && !push_ok;
               if (last_pop) begin
                  state_d = ST_WAIT_VB;
               end
            end
         end
         ST_WAIT_VB: begin
            if (!vblank) begin
               state_d = ST_IDLE;
            end else if (push_ok || (fifo_count != '0)) begin
               state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_en_d    = pop;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = last_pop;
      overflow_d = overflow_q || (oam_we && full);
      if (pop) begin
         wr_addr_d = head_entry[ENTRY_W-1 -: ADDR_W];
         wr_data_d = head_entry[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign cpu_stall   = full;
   assign oam_wr_en   = wr_en_q;
   assign oam_wr_addr = wr_addr_q;
   assign oam_wr_data = wr_data_q;
   assign count       = fifo_count;
   assign overflow    = overflow_q;
   assign drain_done  = done_q;

endmodule

// File: tb/tb_oam_write_queue.sv
// Bench for oam_write_queue: directed scenarios plus random traffic against a queue model.
module tb_oam_write_queue;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       oam_we = 1'b0;
   logic [5:0] oam_snum = '0;
   logic [1:0] oam_field = '0;
   logic [9:0] oam_data = '0;
   logic       vblank = 1'b0;
   logic       cpu_stall, oam_wr_en, overflow, drain_done;
   logic [7:0] oam_wr_addr;
   logic [9:0] oam_wr_data;
   logic [3:0] count;

   oam_write_queue dut (
      .clk         (clk),
      .rst         (rst),
      .oam_we      (oam_we),
      .oam_snum    (oam_snum),
      .oam_field   (oam_field),
      .oam_data    (oam_data),
      .vblank      (vblank),
      .cpu_stall   (cpu_stall),
      .oam_wr_en   (oam_wr_en),
      .oam_wr_addr (oam_wr_addr),
      .oam_wr_data (oam_wr_data),
      .count       (count),
      .overflow    (overflow),
      .drain_done  (drain_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: pending writes as a queue of {addr, data}; waiting = vblank seen with nothing to write.
   int m_q[$];
   bit m_waiting = 1'b0;
   bit m_ovf = 1'b0;
   int m_en = 0, m_addr = 0, m_data = 0, m_done = 0;

   int st_addr[$];
   int st_data[$];
   int st_done[$];

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit we, input int sn, input int fd,
                             input int dt, input bit vb);
      bit push, pop, last;
      int sz;
      if (!r) begin
         m_q.delete();
         m_waiting = 1'b0;
         m_ovf = 1'b0;
         m_en = 0; m_addr = 0; m_data = 0; m_done = 0;
         return;
      end
      sz   = m_q.size();
      push = we && (sz < DEPTH);
      if (we && sz == DEPTH) m_ovf = 1'b1;
      pop  = vb && (sz > 0) && !m_waiting;
      last = pop && (sz == 1) && !push;
      if (!vb) m_waiting = 1'b0;
      else if (m_waiting) begin
         if (push || sz > 0) m_waiting = 1'b0;
      end else if (sz == 0 || last) m_waiting = 1'b1;
      m_en   = pop ? 1 : 0;
      m_done = last ? 1 : 0;
      if (pop) begin
         m_addr = m_q[0] >> 10;
         m_data = m_q[0] & 'h3FF;
         void'(m_q.pop_front());
      end
      if (push) begin
         if (fd >= 2) dt = dt & 'hFF;
         m_q.push_back((((sn & 'h3F) << 2 | (fd & 3)) << 10) | (dt & 'h3FF));
      end
   endtask

   task automatic step(input bit r, input bit we, input int sn, input int fd,
                       input int dt, input bit vb);
      @(negedge clk);
      rst       = r;
      oam_we    = we;
      oam_snum  = 6'(sn);
      oam_field = 2'(fd);
      oam_data  = 10'(dt);
      vblank    = vb;
      @(posedge clk);
      model_step(r, we, sn, fd, dt, vb);
      #1;
   endtask

   task automatic idle(input bit vb, input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0, vb);
   endtask

   task automatic clear_log();
      st_addr.delete();
      st_data.delete();
      st_done.delete();
   endtask

   // Compare every cycle on the falling edge against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_en", 32'(oam_wr_en), m_en);
         chk("wr_addr", 32'(oam_wr_addr), m_addr);
         chk("wr_data", 32'(oam_wr_data), m_data);
         chk("drain_done", 32'(drain_done), m_done);
         chk("count", 32'(count), m_q.size());
         chk("cpu_stall", 32'(cpu_stall), (m_q.size() == DEPTH) ? 1 : 0);
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (oam_wr_en) begin
            st_addr.push_back(32'(oam_wr_addr));
            st_data.push_back(32'(oam_wr_data));
            st_done.push_back(32'(drain_done));
         end
      end
   end

   initial begin
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
      chk_en = 1'b1;
      chk("reset_count", 32'(count), 0);
      chk("reset_wr_en", 32'(oam_wr_en), 0);
      chk("reset_stall", 32'(cpu_stall), 0);
      chk("reset_addr", 32'(oam_wr_addr), 0);

      // Three writes held off until vblank, then replayed back to back.
      step(1'b1, 1'b1, 5, 0, 'h123, 1'b0);
      step(1'b1, 1'b1, 6, 1, 'h0AB, 1'b0);
      step(1'b1, 1'b1, 7, 3, 'h3FF, 1'b0);
      idle(1'b0, 2);
      chk("three_count", 32'(count), 3);
      clear_log();
      idle(1'b1, 5);
      chk("three_strobes", st_addr.size(), 3);
      if (st_addr.size() == 3) begin
         chk("first_addr", st_addr[0], 'h14);
         chk("first_data", st_data[0], 'h123);
         chk("second_addr", st_addr[1], 'h19);
         chk("third_addr", st_addr[2], 'h1F);
         chk("third_data_masked", st_data[2], 'h0FF);
         chk("done_first", st_done[0], 0);
         chk("done_third", st_done[2], 1);
      end
      idle(1'b0, 1);

      // Fill past capacity outside vblank.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i, 0, 'h200 + i, 1'b0);
      chk("full_stall", 32'(cpu_stall), 1);
      chk("full_count", 32'(count), 8);
      chk("full_no_ovf", 32'(overflow), 0);
      step(1'b1, 1'b1, 9, 0, 'h2FF, 1'b0);
      chk("drop_ovf", 32'(overflow), 1);
      chk("drop_count", 32'(count), 8);

      // Reset in the middle of a drain.
      idle(1'b1, 4);
      chk("mid_drain_count", 32'(count), 4);
      step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      chk("rst_count", 32'(count), 0);
      chk("rst_wr_en", 32'(oam_wr_en), 0);
      chk("rst_ovf", 32'(overflow), 0);
      idle(1'b0, 2);

      // Short vblank: two writes go out, the rest wait for the next one.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 10 + i, 1, 'h10 + i, 1'b0);
      clear_log();
      idle(1'b1, 2);
      idle(1'b0, 2);
      chk("short_vb_strobes", st_addr.size(), 2);
      chk("short_vb_count", 32'(count), 4);
      idle(1'b1, 6);
      idle(1'b0, 1);
      chk("resume_strobes", st_addr.size(), 6);
      chk("resume_count", 32'(count), 0);
      for (int i = 0; i < st_data.size(); i++) chk("resume_order", st_data[i], 'h10 + i);

      // Streaming push during vblank keeps occupancy flat.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 20 + i, 0, 'h40 + i, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 30 + i, 2, 'h300 + i, 1'b1);
         chk("stream_count", 32'(count), 3);
      end
      chk("stream_no_ovf", 32'(overflow), 0);
      idle(1'b1, 5);
      idle(1'b0, 1);

      // Randomised traffic, including rare resets and pointer wrap.
      begin
         bit vb = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) vb = ~vb;
            step(($urandom_range(499) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(9) < 6) ? 1'b1 : 1'b0,
                 int'($urandom_range(63)), int'($urandom_range(3)),
                 int'($urandom_range(1023)), vb);
         end
      end
      idle(1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
